// File: rtl/dac_sweep_ctrl_pkg.sv
// Shared types and constants for the DAC sweep sequencer.
package dac_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DC_PRE,
    S_CONFIG,
    S_SYNC,
    S_SETTLE,
    S_MEAS,
    S_NEXT
  } state_t;

  localparam int unsigned TABLE_LEN = 2048;
  localparam int unsigned PTOS_MIN  = 2;

  function automatic logic [15:0] ptos_sat(input logic [27:0] v);
    return (v > 28'(TABLE_LEN)) ? 16'(TABLE_LEN) : v[15:0];
  endfunction

endpackage

// File: rtl/dac_sweep_ctrl_if.sv
// Host-configuration and DAC-source signal bundle of the sweep sequencer.
interface dac_sweep_ctrl_if #(
  parameter int unsigned N_STEPS_W = 8
);
  logic                 start;
  logic                 abort;
  logic [15:0]          ptos_start;
  logic [15:0]          ptos_inc;
  logic [N_STEPS_W-1:0] n_steps;
  logic                 zero_cross;
  logic                 src_ce;
  logic [15:0]          src_ptos;
  logic                 src_sel_dc;
  logic                 src_rst_n;
  logic                 meas_window;
  logic [N_STEPS_W-1:0] step_idx;
  logic                 busy;
  logic                 done;
  logic                 error;

  modport slave (
    input  start, abort, ptos_start, ptos_inc, n_steps, zero_cross,
    output src_ce, src_ptos, src_sel_dc, src_rst_n, meas_window,
           step_idx, busy, done, error
  );

  modport master (
    output start, abort, ptos_start, ptos_inc, n_steps, zero_cross,
    input  src_ce, src_ptos, src_sel_dc, src_rst_n, meas_window,
           step_idx, busy, done, error
  );
endinterface

// File: rtl/dac_sweep_ctrl_zc_period_counter.sv
// Zero-crossing edge detector with period counter and inter-edge timeout.
module zc_period_counter #(
  parameter int unsigned CNT_W        = 5,
  parameter int unsigned TIMEOUT_CLKS = 1048576
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             zero_cross,
  input  logic             run,
  input  logic             clear,
  output logic             zc_edge,
  output logic [CNT_W-1:0] periods,
  output logic             timeout
);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS) + 1;

  logic             zc_q;
  logic [TMO_W-1:0] tmo_q;

  assign zc_edge = zero_cross & ~zc_q;
  assign timeout = run & ~zc_edge & (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zc_q    <= 1'b0;
      periods <= '0;
      tmo_q   <= '0;
    end else begin
      zc_q <= zero_cross;
      if (clear)
        periods <= '0;
      else if (run && zc_edge)
        periods <= periods + CNT_W'(1);
      if (!run || zc_edge)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + TMO_W'(1);
    end
  end
endmodule

// File: rtl/dac_sweep_ctrl.sv
// Sweep sequencer: steps the sine source through an arithmetic ptos sweep
// with zero-crossing resync, settling discard and a measurement window.
module dac_sweep_ctrl
  import dac_sweep_ctrl_pkg::*;
#(
  parameter int unsigned N_STEPS_W      = 8,
  parameter int unsigned SETTLE_PERIODS = 2,
  parameter int unsigned MEAS_PERIODS   = 16,
  parameter int unsigned DC_PRE_CLKS    = 64,
  parameter int unsigned TIMEOUT_CLKS   = 1048576
) (
  input logic             clock,
  input logic             reset_n,
  dac_sweep_ctrl_if.slave bus
);
  localparam int unsigned PER_MAX     = (SETTLE_PERIODS > MEAS_PERIODS) ? SETTLE_PERIODS : MEAS_PERIODS;
  localparam int unsigned PER_W       = $clog2(PER_MAX + 1);
  localparam int unsigned PH_MAX      = (DC_PRE_CLKS > 3) ? DC_PRE_CLKS : 3;
  localparam int unsigned PH_W        = $clog2(PH_MAX + 1);
  localparam int unsigned SETTLE_LAST = (SETTLE_PERIODS > 0) ? SETTLE_PERIODS - 1 : 0;
  localparam int unsigned MEAS_LAST   = (MEAS_PERIODS > 0) ? MEAS_PERIODS - 1 : 0;

  state_t               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [N_STEPS_W-1:0] step_q, step_d;
  logic                 error_q, error_d, done_d;
  logic                 done_q, busy_q, src_ce_q, sel_dc_q, src_rst_n_q, meas_q;
  logic [15:0]          ptos_q;
  logic                 ptos_loaded_q;
  logic [27:0]          ptos_raw;
  logic                 zc_edge, zc_timeout, run, per_clear, cfg_bad, last_step;
  logic [PER_W-1:0]     periods;

  assign cfg_bad   = (bus.n_steps == '0) || (bus.ptos_start < 16'(PTOS_MIN)) ||
                     (bus.ptos_start > 16'(TABLE_LEN));
  assign last_step = (step_q == bus.n_steps - N_STEPS_W'(1));
  assign run       = state_q inside {S_SYNC, S_SETTLE, S_MEAS};
  assign per_clear = (state_d != state_q);
  assign ptos_raw  = 28'(bus.ptos_start) + 28'(step_d) * 28'(bus.ptos_inc);

  zc_period_counter #(
    .CNT_W        (PER_W),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_zc (
    .clock      (clock),
    .reset_n    (reset_n),
    .zero_cross (bus.zero_cross),
    .run        (run),
    .clear      (per_clear),
    .zc_edge    (zc_edge),
    .periods    (periods),
    .timeout    (zc_timeout)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    error_d = error_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cfg_bad) begin
            error_d = 1'b1;
          end else begin
            state_d = S_DC_PRE;
            error_d = 1'b0;
            step_d  = '0;
          end
        end
      end
      S_DC_PRE: if (phase_q == PH_W'(DC_PRE_CLKS - 1)) state_d = S_CONFIG;
      S_CONFIG: if (phase_q == PH_W'(2)) state_d = S_SYNC;
      S_SYNC:   if (zc_edge) state_d = (SETTLE_PERIODS == 0) ? S_MEAS : S_SETTLE;
      S_SETTLE: if (zc_edge && periods == PER_W'(SETTLE_LAST)) state_d = S_MEAS;
      S_MEAS:   if (zc_edge && periods == PER_W'(MEAS_LAST)) state_d = S_NEXT;
      S_NEXT: begin
        if (last_step) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_CONFIG;
          step_d  = step_q + N_STEPS_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (zc_timeout) begin
      state_d = S_IDLE;
      error_d = 1'b1;
    end
    if (bus.abort) begin
      state_d = S_IDLE;
      step_d  = step_q;
      error_d = error_q;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    phase_d = '0;
    if ((state_d == state_q) && (state_q inside {S_DC_PRE, S_CONFIG}))
      phase_d = phase_q + PH_W'(1);
  end

  // Outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      step_q        <= '0;
      error_q       <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      src_ce_q      <= 1'b0;
      sel_dc_q      <= 1'b0;
      src_rst_n_q   <= 1'b1;
      meas_q        <= 1'b0;
      ptos_q        <= '0;
      ptos_loaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      error_q     <= error_d;
      done_q      <= done_d;
      busy_q      <= (state_d != S_IDLE);
      src_ce_q    <= state_d inside {S_DC_PRE, S_SYNC, S_SETTLE, S_MEAS, S_NEXT};
      sel_dc_q    <= (state_d == S_DC_PRE);
      src_rst_n_q <= !((state_d == S_CONFIG) && (phase_d == PH_W'(1)));
      meas_q      <= (state_d == S_MEAS);
      if ((state_d == S_CONFIG) && (state_q != S_CONFIG)) begin
        ptos_q        <= ptos_sat(ptos_raw);
        ptos_loaded_q <= 1'b1;
      end
    end
  end

  // Until the first CONFIG load the source length follows the clamped ptos_start,
  // which is what the source shows out of reset.
  assign bus.src_ptos    = ptos_loaded_q ? ptos_q : ptos_sat(28'(bus.ptos_start));
  assign bus.src_ce      = src_ce_q;
  assign bus.src_sel_dc  = sel_dc_q;
  assign bus.src_rst_n   = src_rst_n_q;
  assign bus.meas_window = meas_q;
  assign bus.step_idx    = step_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// Scoreboard bench for dac_sweep_ctrl with a behavioural table-source model.
module tb_dac_sweep_ctrl;
  localparam int unsigned NW      = 8;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned MEAS    = 4;
  localparam int unsigned DC_PRE  = 8;
  localparam int unsigned TIMEOUT = 5000;

  typedef struct { int step; int ptos; int len; bit aborted; } win_t;
  typedef struct { bit done; bit err; int step; bit tmo; } end_t;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  win_t exp_win[$];
  end_t exp_end[$];

  dac_sweep_ctrl_if #(.N_STEPS_W(NW)) bus ();

  dac_sweep_ctrl #(
    .N_STEPS_W      (NW),
    .SETTLE_PERIODS (SETTLE),
    .MEAS_PERIODS   (MEAS),
    .DC_PRE_CLKS    (DC_PRE),
    .TIMEOUT_CLKS   (TIMEOUT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Source model: sample phase wraps every src_ptos clocks; zero_cross high for `hold` samples.
  int phase = 0;
  int hold  = 1;
  bit zc_kill = 1'b0;
  always @(posedge clock) begin
    if (!reset_n || !bus.src_rst_n) phase <= 0;
    else if (bus.src_ce) phase <= (phase + 1 >= int'(bus.src_ptos)) ? 0 : phase + 1;
  end
  assign bus.zero_cross = !zc_kill && (phase < hold);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations when a window closes or a sweep ends.
  bit prev_meas = 1'b0, prev_busy = 1'b0, prev_rst = 1'b1;
  int wlen = 0, wptos = 0, wstep = 0, rlen = 0, ce_run = 0;
  always @(negedge clock) begin
    win_t w;
    end_t e;
    if (reset_n) begin
      if (bus.meas_window) begin
        if (!prev_meas) begin
          wlen  = 0;
          wptos = int'(bus.src_ptos);
          wstep = int'(bus.step_idx);
        end
        wlen++;
      end else if (prev_meas) begin
        if (exp_win.size() == 0) begin
          checks++; errors++;
          $display("FAIL win_unexpected: step %0d len %0d, none expected", wstep, wlen);
        end else begin
          w = exp_win.pop_front();
          chk("win_step", wstep, w.step);
          chk("win_ptos", wptos, w.ptos);
          chk("win_aborted", int'(!bus.busy), int'(w.aborted));
          if (w.aborted) chk("abort_src_ce", int'(bus.src_ce), 0);
          else           chk("win_len", wlen, w.len);
        end
      end
      if (!bus.src_rst_n) begin
        rlen++;
        chk("rst_src_ce", int'(bus.src_ce), 0);
      end else if (!prev_rst) begin
        chk("rst_len", rlen, 1);
        rlen = 0;
      end
      if (!bus.src_rst_n) ce_run = 0;
      else if (bus.src_ce) ce_run++;
      if (prev_busy && !bus.busy) begin
        if (exp_end.size() == 0) begin
          checks++; errors++;
          $display("FAIL end_unexpected: sweep ended, none expected");
        end else begin
          e = exp_end.pop_front();
          chk("end_done", int'(bus.done), int'(e.done));
          chk("end_error", int'(bus.error), int'(e.err));
          chk("end_step", int'(bus.step_idx), e.step);
          if (e.tmo) chk("timeout_clks", ce_run, int'(TIMEOUT));
        end
      end
      prev_meas = bus.meas_window;
      prev_busy = bus.busy;
      prev_rst  = bus.src_rst_n;
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!bus.busy) break;
    end
    if (bus.busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still 1 after %0d clocks, required 0", budget);
    end
    @(negedge clock);
  endtask

  task automatic push_win(input int step, input int ptos, input int len, input bit ab);
    win_t w;
    w.step = step; w.ptos = ptos; w.len = len; w.aborted = ab;
    exp_win.push_back(w);
  endtask

  task automatic push_end(input bit dn, input bit er, input int step, input bit tmo);
    end_t e;
    e.done = dn; e.err = er; e.step = step; e.tmo = tmo;
    exp_end.push_back(e);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.ptos_start = 16'd16;
    bus.ptos_inc   = 16'd16;
    bus.n_steps    = 8'd3;
    repeat (3) @(negedge clock);
    chk("rst_src_ce", int'(bus.src_ce), 0);
    chk("rst_src_ptos", int'(bus.src_ptos), 16);
    chk("rst_sel_dc", int'(bus.src_sel_dc), 0);
    chk("rst_src_rst_n", int'(bus.src_rst_n), 1);
    chk("rst_meas", int'(bus.meas_window), 0);
    chk("rst_step", int'(bus.step_idx), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_error", int'(bus.error), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic sweep 16/32/48
    push_win(0, 16, 4 * 16, 1'b0);
    push_win(1, 32, 4 * 32, 1'b0);
    push_win(2, 48, 4 * 48, 1'b0);
    push_end(1'b1, 1'b0, 2, 1'b0);
    pulse_start();
    chk("start_busy", int'(bus.busy), 1);
    chk("start_sel_dc", int'(bus.src_sel_dc), 1);
    wait_idle(5000);

    // Saturation: 2000, 2100 -> 2048
    bus.ptos_start = 16'd2000;
    bus.ptos_inc   = 16'd100;
    bus.n_steps    = 8'd2;
    push_win(0, 2000, 4 * 2000, 1'b0);
    push_win(1, 2048, 4 * 2048, 1'b0);
    push_end(1'b1, 1'b0, 1, 1'b0);
    pulse_start();
    wait_idle(40000);

    // n_steps = 0 rejected
    bus.n_steps = 8'd0;
    pulse_start();
    @(negedge clock);
    chk("nsteps0_error", int'(bus.error), 1);
    chk("nsteps0_busy", int'(bus.busy), 0);

    // Wide crossings (held 5 clocks) count once; valid start clears error
    hold           = 5;
    bus.ptos_start = 16'd16;
    bus.ptos_inc   = 16'd16;
    bus.n_steps    = 8'd2;
    push_win(0, 16, 4 * 16, 1'b0);
    push_win(1, 32, 4 * 32, 1'b0);
    push_end(1'b1, 1'b0, 1, 1'b0);
    pulse_start();
    chk("restart_error_clr", int'(bus.error), 0);
    chk("restart_busy", int'(bus.busy), 1);
    wait_idle(5000);
    hold = 1;

    // ptos_start below minimum rejected
    bus.ptos_start = 16'd1;
    pulse_start();
    @(negedge clock);
    chk("ptos1_error", int'(bus.error), 1);
    chk("ptos1_busy", int'(bus.busy), 0);

    // Timeout in SYNC
    bus.ptos_start = 16'd16;
    zc_kill        = 1'b1;
    push_end(1'b0, 1'b1, 0, 1'b1);
    pulse_start();
    chk("tmo_start_error_clr", int'(bus.error), 0);
    wait_idle(TIMEOUT + 1000);
    chk("tmo_src_ce", int'(bus.src_ce), 0);
    zc_kill = 1'b0;

    // start and abort together in IDLE: abort wins, error untouched
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_busy", int'(bus.busy), 0);
    chk("abort_start_error", int'(bus.error), 1);

    // Abort during MEAS of step 1
    bus.n_steps = 8'd3;
    push_win(0, 16, 4 * 16, 1'b0);
    push_win(1, 32, 0, 1'b1);
    push_end(1'b0, 1'b0, 1, 1'b0);
    pulse_start();
    for (int i = 0; i < 5000; i++) begin
      if (bus.meas_window && bus.step_idx == 8'd1) break;
      @(negedge clock);
    end
    chk("reach_meas_step1", int'(bus.meas_window && bus.step_idx == 8'd1), 1);
    repeat (5) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    chk("abort_meas", int'(bus.meas_window), 0);
    chk("abort_src_ce_now", int'(bus.src_ce), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    repeat (10) @(negedge clock);
    chk("abort_no_late_done", int'(bus.done), 0);
    chk("win_queue_left", exp_win.size(), 0);
    chk("end_queue_left", exp_end.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_sweep_ctrl.md
# dac_sweep_ctrl

Sequencer for the table-based sine DAC source. It steps the source through a programmed arithmetic sweep of points-per-cycle values. For each step it reconfigures the source while stalled, resynchronises on zero crossings and discards settling periods. It then opens a measurement window spanning an integer number of signal periods. The block sits between the host configuration registers and the DAC data source, and drives the source's enable, length, DC-select and reset inputs.

## Interface
- N_STEPS_W, 8, width of step count and step index
- SETTLE_PERIODS, 2, signal periods discarded after each reconfiguration
- MEAS_PERIODS, 16, signal periods inside each measurement window
- DC_PRE_CLKS, 64, clocks of DC level output before the first step
- TIMEOUT_CLKS, 1048576, maximum clocks between zero crossings before error

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-clock pulse, begins a sweep when idle
- abort  in  1  level; forces return to IDLE
- ptos_start  in  16  points per cycle of step 0
- ptos_inc  in  16  increment per step
- n_steps  in  N_STEPS_W  number of steps (0 = error)
- zero_cross  in  1  from source
- src_ce  out  1  source enable
- src_ptos  out  16  source points per cycle
- src_sel_dc  out  1  source DC select
- src_rst_n  out  1  registered source reset, active low
- meas_window  out  1  high during measurement periods
- step_idx  out  N_STEPS_W  current step
- busy  out  1  not IDLE
- done  out  1  one-clock pulse at sweep completion
- error  out  1  sticky until next accepted start

## Operation
- All outputs are registered. Reset values: src_ce=0, src_ptos=ptos_start clamp, src_sel_dc=0, src_rst_n=1, meas_window=0, step_idx=0, busy=0, done=0, error=0.
- States: IDLE, DC_PRE, CONFIG, SYNC, SETTLE, MEAS, NEXT.
- IDLE: start and valid configuration -> DC_PRE, clear error, step_idx=0. Invalid configuration sets error=1 and the block stays in IDLE:
  - n_steps=0, or
  - ptos_start<2, or
  - ptos_start>2048.
- DC_PRE: src_ce=1, src_sel_dc=1 for DC_PRE_CLKS clocks -> CONFIG.
- CONFIG: lasts 3 clocks.
  - Clock 0: src_ce=0, src_sel_dc=0; load src_ptos.
  - Clock 1: src_rst_n=0.
  - Clock 2: src_rst_n=1.
  - Then -> SYNC.
- SYNC: src_ce=1; on the first zero_cross rising edge -> SETTLE.
- SETTLE: count SETTLE_PERIODS rising edges -> MEAS. SETTLE_PERIODS=0 skips straight to MEAS.
- MEAS: meas_window=1; count MEAS_PERIODS rising edges, then clear meas_window -> NEXT.
- NEXT: if step_idx==n_steps-1: done pulse, src_ce=0 -> IDLE. Otherwise step_idx+1 -> CONFIG.
- src_ptos = ptos_start + step_idx*ptos_inc, computed in 28 bits and saturated to 2048.
- Zero-crossing edge detect: register zero_cross; edge = zero_cross & ~zero_cross_q. A crossing that is held high for several clocks counts once.
- Timeout: a clock counter runs in SYNC, SETTLE and MEAS and resets on each edge. Reaching TIMEOUT_CLKS sets error=1 and goes to IDLE with src_ce=0.
- abort: takes priority over everything, in any state. Next clock: IDLE, src_ce=0, meas_window=0, no done pulse.
- start while busy is ignored.
- start and abort in the same IDLE cycle: abort wins.

## Timing
- start at clock T -> busy=1 and src_sel_dc=1 at T+1.
- CONFIG exit -> src_ce=1 at the next clock. The source is in reset for exactly one clock and sees the new ptos at least one clock before reset releases.
- Edge counts complete on the clock the edge is detected; the state change is visible one clock later.
- meas_window rises the clock after the terminal SETTLE edge. It falls the clock after the MEAS_PERIODS-th edge in MEAS.
- done: high for exactly one clock, coincident with busy falling.
- reset_n asserted mid-sweep: all outputs return to reset values immediately. src_rst_n stays 1; the source has its own reset.

## Structure
- Shared package: state enum, the 2048 table length, ptos minimum constant (2).
- One natural sub-module: zc_period_counter (edge detect, period count, timeout), instantiated once.

## Test plan
- Sweep with ptos_start=16, ptos_inc=16, n_steps=3, SETTLE_PERIODS=2, MEAS_PERIODS=4 -> src_ptos 16, 32, 48. Each window spans exactly 4×src_ptos source samples. done pulses once; step_idx ends at 2.
- ptos_start=2000, ptos_inc=100, n_steps=2 -> second step src_ptos=2048 (saturated).
- start with n_steps=0 -> error=1, busy stays 0. Next valid start clears error.
- Hold zero_cross low in SYNC -> error=1 after TIMEOUT_CLKS clocks, src_ce=0, IDLE.
- abort during MEAS of step 1 -> next clock meas_window=0, src_ce=0, busy=0, no done.
- zero_cross held high for 5 clocks per crossing -> counted as one period. Window length is unchanged.
